// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - sequential signed 32-bit multiplier/divider for the execute stage
module multdiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic             is_mult_q;
    logic             neg_q;
    logic             div_exc_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mag_a_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [2*WIDTH-1:0] acc_q;

    logic             start;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_exc_d;
    logic [WIDTH:0]   mult_sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0] quot_signed;
    logic             mult_exc;
    logic [WIDTH-1:0] result_d;
    logic             exc_d;

    // Operand magnitudes, one iteration step of each datapath, and final sign fix-up
    always_comb begin
        start     = ctrl_MULT | ctrl_DIV;
        abs_a     = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        abs_b     = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;
        // Divide-by-zero and the single quotient that does not fit are flagged up front
        div_exc_d = (data_operandB == '0) ||
                    ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1));

        // Shift-add: upper half accumulates the multiplicand when the multiplier LSB is set
        mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_a_q};
        mult_next = acc_q[0] ? {mult_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

        // Restoring divide: upper half is the partial remainder, lower half the dividend/quotient
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        if (div_shift >= {1'b0, mag_b_q}) begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end

        prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot_signed = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        // Product fits in WIDTH signed bits only if the top WIDTH+1 bits are a pure sign extension
        mult_exc    = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));

        if (is_mult_q) begin
            result_d = prod_signed[WIDTH-1:0];
            exc_d    = mult_exc;
        end else if (div_exc_q) begin
            result_d = '0;
            exc_d    = 1'b1;
        end else begin
            result_d = quot_signed;
            exc_d    = 1'b0;
        end
    end

    // Control FSM with registered outputs; a start pulse in any state restarts the unit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            is_mult_q      <= 1'b0;
            neg_q          <= 1'b0;
            div_exc_q      <= 1'b0;
            cnt_q          <= '0;
            mag_a_q        <= '0;
            mag_b_q        <= '0;
            acc_q          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                state_q   <= ctrl_MULT ? S_MULT : S_DIV;
                is_mult_q <= ctrl_MULT;
                neg_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_exc_q <= ctrl_MULT ? 1'b0 : div_exc_d;
                cnt_q     <= '0;
                mag_a_q   <= abs_a;
                mag_b_q   <= abs_b;
                acc_q     <= ctrl_MULT ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
                busy      <= 1'b1;
            end else begin
                case (state_q)
                    S_MULT, S_DIV: begin
                        acc_q <= (state_q == S_MULT) ? mult_next : div_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        data_result    <= result_d;
                        data_exception <= exc_d;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
